abro_arbiter: RTL and testbench
===============================

ABRO_ARBITER -- requirements
Module: abro_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL have ports, in this order:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous reset, active-high
- req_valid  input  2  per-requester event valid
- req_a  input  2  per-requester A event
- req_b  input  2  per-requester B event
- req_r  input  2  per-requester R (restart) event
- req_ready  output  2  per-requester grant, one-hot or zero
- O  output  1  high while core is in STATE_O
- state  output  4  core state, one-hot
- o_owner  output  1  index of requester whose transfer entered STATE_O
- o_count  output  8  number of STATE_O entries, saturating

Function
REQ-003 Transfer on requester i SHALL occur when req_valid[i] and req_ready[i] are both high at a rising clk edge.
REQ-004 req_ready SHALL be combinational from req_valid, the round-robin pointer, state and o_owner.
- At most one bit of req_ready SHALL be high.
- A bit SHALL never be high without its req_valid bit.
REQ-005 Arbitration outside STATE_O:
- Sole valid requester SHALL be granted.
- If both are valid, the requester not granted most recently SHALL win.
- Pointer resets to favour requester 0.
REQ-006 In STATE_O, only requester o_owner SHALL be grantable; the other requester's ready SHALL stay low.
REQ-007 Requesters SHALL hold req_valid and payload stable until transferred. The block does not check this rule; behaviour when it is broken is unspecified.
REQ-008 Core state encoding SHALL be IDLE=0001, SEEN_A=0010, SEEN_B=0100, STATE_O=1000.
REQ-009 Transitions SHALL apply only at transfer edges, using the granted payload. Otherwise the state holds.
- R high: next state is IDLE, with priority over A and B, from any state.
- IDLE: A&B goes to STATE_O; A goes to SEEN_A; B goes to SEEN_B; neither holds.
- SEEN_A: B goes to STATE_O; otherwise holds.
- SEEN_B: A goes to STATE_O; otherwise holds.
- STATE_O: A and/or B without R holds.
REQ-010 state and O SHALL reflect a transfer one cycle after its edge, i.e. they are registered. O SHALL equal state[3].
REQ-011 o_owner SHALL be loaded with the granted index on the edge entering STATE_O, and held otherwise.
REQ-012 o_count SHALL increment by 1 on each edge entering STATE_O, saturating at 255.
- Re-entry after R counts again.
- Staying in STATE_O SHALL NOT count.
REQ-013 A transfer with A=B=R=0 SHALL be accepted and SHALL change nothing except the round-robin pointer.

Reset
REQ-014 While reset is high at a clk edge, the following SHALL be set:
- state=0001, O=0
- o_owner=0, o_count=0
- pointer favours requester 0
REQ-015 req_ready SHALL be forced to 00 while reset is high, and no transfer SHALL occur.
REQ-016 Reset mid-sequence (any state) SHALL discard progress. The first post-reset transfer SHALL be evaluated from IDLE.

Structure
REQ-017 A shared package SHALL hold:
- the four state encodings
- the requester count (2)
- the counter width (8)
REQ-018 The ABRO next-state logic and state register SHALL be one sub-module, abro_core (inputs: clk, reset, ev_valid, A, B, R; outputs: state, O). abro_arbiter SHALL own the arbitration, owner lock and counter.

Verification
REQ-019 Bench SHALL cover:
- Reset then idle: state=0001, O=0, o_count=0, req_ready=00 during reset.
- Requester 0 sends A, then requester 1 sends B: state goes 0010 then 1000; O=1; o_owner=1; o_count=1.
- Both valid each cycle, payload A=B=0: grants alternate 01,10,01,10.
- In STATE_O with owner 1, requester 0 valid: req_ready[0] stays 0 until requester 1 sends R; state returns to 0001 and requester 0 is then granted.
- A=B=1 in one transfer from IDLE: 1000 next cycle; 256 enter/R cycles leave o_count=255.
- Assert reset while in SEEN_B: state becomes 0001; a following A goes to 0010, not 1000.

Source files
------------

// File: rtl/abro_arbiter_pkg.sv
// Shared definitions for the two-requester ABRO arbiter: state encodings,
// sizing constants and the ABRO next-state function used by core and arbiter.
package abro_arbiter_pkg;

  localparam int N_REQ = 2;
  localparam int CNT_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_SEEN_A = 4'b0010,
    ST_SEEN_B = 4'b0100,
    ST_O      = 4'b1000
  } state_e;

  // R wins over A/B from any state; unknown encodings recover to IDLE.
  function automatic state_e abro_next(state_e cur, logic a, logic b, logic r);
    state_e nxt;
    nxt = cur;
    if (r) begin
      nxt = ST_IDLE;
    end else begin
      case (cur)
        ST_IDLE: begin
          if (a && b)  nxt = ST_O;
          else if (a)  nxt = ST_SEEN_A;
          else if (b)  nxt = ST_SEEN_B;
        end
        ST_SEEN_A: if (b) nxt = ST_O;
        ST_SEEN_B: if (a) nxt = ST_O;
        ST_O:      nxt = ST_O;
        default:   nxt = ST_IDLE;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/abro_core.sv
// ABRO state register: advances only on an accepted event, otherwise holds.
module abro_core
  import abro_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ev_valid,
  input  logic       A,
  input  logic       B,
  input  logic       R,
  output logic [3:0] state,
  output logic       O
);

  state_e state_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else if (ev_valid) begin
      state_q <= abro_next(state_q, A, B, R);
    end
  end

  assign state = state_q;
  assign O     = state_q[3];

endmodule

// File: rtl/abro_arbiter.sv
// Round-robin front end for the ABRO core: grants one requester per cycle,
// locks grants to the owner while in STATE_O, and counts STATE_O entries.
module abro_arbiter
  import abro_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [N_REQ-1:0] req_a,
  input  logic [N_REQ-1:0] req_b,
  input  logic [N_REQ-1:0] req_r,
  output logic [N_REQ-1:0] req_ready,
  output logic             O,
  output logic [3:0]       state,
  output logic             o_owner,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic             rr_q, rr_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             xfer, gnt_idx, ev_a, ev_b, ev_r, enter_o;

  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    req_ready = '0;
    if (!reset) begin
      if (state == ST_O)       req_ready[owner_q] = req_valid[owner_q];
      else if (&req_valid)     req_ready[rr_q]    = 1'b1;
      else                     req_ready          = req_valid;
    end
  end

  // A ready bit is only ever set alongside its valid, so ready alone marks a transfer.
  assign xfer    = |req_ready;
  assign gnt_idx = req_ready[1];
  assign ev_a    = req_a[gnt_idx];
  assign ev_b    = req_b[gnt_idx];
  assign ev_r    = req_r[gnt_idx];
  assign enter_o = xfer && (state != ST_O) &&
                   (abro_next(state_e'(state), ev_a, ev_b, ev_r) == ST_O);

  always_comb begin
    rr_d    = xfer ? ~gnt_idx : rr_q;
    owner_d = enter_o ? gnt_idx : owner_q;
    cnt_d   = (enter_o && cnt_q != '1) ? cnt_q + CNT_ONE : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  abro_core u_core (
    .clk      (clk),
    .reset    (reset),
    .ev_valid (xfer),
    .A        (ev_a),
    .B        (ev_b),
    .R        (ev_r),
    .state    (state),
    .O        (O)
  );

  assign o_owner = owner_q;
  assign o_count = cnt_q;

endmodule

// File: tb/tb_abro_arbiter.sv
// Directed bench for abro_arbiter: inputs change 1 ns after a rising edge,
// and outputs are compared before the next edge.
module tb_abro_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid, req_a, req_b, req_r;
  logic [1:0] req_ready;
  logic       O;
  logic [3:0] state;
  logic       o_owner;
  logic [7:0] o_count;

  int n_tests = 0;
  int n_fail  = 0;

  abro_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_r     (req_r),
    .req_ready (req_ready),
    .O         (O),
    .state     (state),
    .o_owner   (o_owner),
    .o_count   (o_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] a,
                       input logic [1:0] b, input logic [1:0] r);
    req_valid = v; req_a = a; req_b = b; req_r = r;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 2'b00);
    tick;

    // Reset: ready forced low even with both requesters valid.
    drive(2'b11, 2'b11, 2'b11, 2'b00);
    check("rst_ready", req_ready, 2'b00);
    tick;
    check("rst_ready2", req_ready, 2'b00);
    check("rst_state", state, 4'b0001);
    check("rst_O", O, 1'b0);
    check("rst_count", o_count, 8'd0);
    check("rst_owner", o_owner, 1'b0);

    // Idle after reset.
    reset = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 2'b00);
    check("idle_ready", req_ready, 2'b00);
    tick;
    check("idle_state", state, 4'b0001);

    // Both valid, empty payload: grants alternate starting with requester 0.
    drive(2'b11, 2'b00, 2'b00, 2'b00);
    check("rr_g0", req_ready, 2'b01);
    tick;
    check("rr_g1", req_ready, 2'b10);
    tick;
    check("rr_g2", req_ready, 2'b01);
    tick;
    check("rr_g3", req_ready, 2'b10);
    tick;
    check("rr_state", state, 4'b0001);
    check("rr_count", o_count, 8'd0);

    // Requester 0 sends A, requester 1 sends B.
    drive(2'b01, 2'b01, 2'b00, 2'b00);
    check("a_ready", req_ready, 2'b01);
    tick;
    check("a_state", state, 4'b0010);
    drive(2'b10, 2'b00, 2'b10, 2'b00);
    check("b_ready", req_ready, 2'b10);
    tick;
    check("o_state", state, 4'b1000);
    check("o_O", O, 1'b1);
    check("o_owner", o_owner, 1'b1);
    check("o_count1", o_count, 8'd1);

    // Owner lock: requester 0 blocked until owner 1 sends R.
    drive(2'b01, 2'b01, 2'b00, 2'b00);
    check("lock_ready0", req_ready, 2'b00);
    tick;
    check("lock_ready1", req_ready, 2'b00);
    check("lock_state", state, 4'b1000);
    drive(2'b11, 2'b01, 2'b00, 2'b10);
    check("lock_owner_ready", req_ready, 2'b10);
    tick;
    check("r_state", state, 4'b0001);
    check("r_O", O, 1'b0);
    drive(2'b01, 2'b01, 2'b00, 2'b00);
    check("unlock_ready", req_ready, 2'b01);
    tick;
    check("unlock_state", state, 4'b0010);

    // Empty transfer in SEEN_A changes nothing.
    drive(2'b01, 2'b00, 2'b00, 2'b00);
    check("nop_ready", req_ready, 2'b01);
    tick;
    check("nop_state", state, 4'b0010);
    check("nop_count", o_count, 8'd1);

    // Reset, then A=B=1 in one transfer.
    reset = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 2'b00);
    tick;
    reset = 1'b0;
    check("rst2_count", o_count, 8'd0);
    drive(2'b01, 2'b01, 2'b01, 2'b00);
    tick;
    check("ab_state", state, 4'b1000);
    check("ab_count", o_count, 8'd1);
    check("ab_owner", o_owner, 1'b0);
    drive(2'b01, 2'b01, 2'b00, 2'b00);
    tick;
    check("stay_state", state, 4'b1000);
    check("stay_count", o_count, 8'd1);
    drive(2'b01, 2'b00, 2'b00, 2'b01);
    tick;
    check("ab_r_state", state, 4'b0001);

    // 255 further enter/R cycles: 256 entries total saturate at 255.
    for (int i = 0; i < 255; i++) begin
      drive(2'b01, 2'b01, 2'b01, 2'b00);
      tick;
      if (i == 252) check("sat_254", o_count, 8'd254);
      drive(2'b01, 2'b00, 2'b00, 2'b01);
      tick;
    end
    check("sat_count", o_count, 8'd255);
    check("sat_state", state, 4'b0001);

    // Reset while in SEEN_B discards progress.
    drive(2'b10, 2'b00, 2'b10, 2'b00);
    tick;
    check("sb_state", state, 4'b0100);
    reset = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 2'b00);
    tick;
    reset = 1'b0;
    check("sb_rst_state", state, 4'b0001);
    drive(2'b01, 2'b01, 2'b00, 2'b00);
    tick;
    check("sb_after_a", state, 4'b0010);
    check("sb_after_count", o_count, 8'd0);

    drive(2'b00, 2'b00, 2'b00, 2'b00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
